// File: rtl/fpu_cvxif_sequencer.sv
// CV-X-IF single-outstanding sequencer in front of fpnew_top (RV32F, no regs).
// Ports: x_issue/x_commit/x_result to the core, fpu_* to fpnew, frm_i/fflags_o CSR side.
module fpu_cvxif_sequencer #(
  parameter int unsigned IdWidth       = 4,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               x_issue_valid_i,
  output logic               x_issue_ready_o,
  input  logic [31:0]        x_issue_instr_i,
  input  logic [IdWidth-1:0] x_issue_id_i,
  input  logic [31:0]        x_issue_rs0_i,
  input  logic [31:0]        x_issue_rs1_i,
  output logic               x_issue_accept_o,
  output logic               x_issue_writeback_o,
  input  logic               x_commit_valid_i,
  input  logic [IdWidth-1:0] x_commit_id_i,
  input  logic               x_commit_kill_i,
  output logic               x_result_valid_o,
  input  logic               x_result_ready_i,
  output logic [IdWidth-1:0] x_result_id_o,
  output logic [4:0]         x_result_rd_o,
  output logic [31:0]        x_result_data_o,
  output logic               x_result_we_o,
  input  logic [2:0]         frm_i,
  output logic [4:0]         fflags_o,
  input  logic               fflags_clr_i,
  output logic               fpu_in_valid_o,
  input  logic               fpu_in_ready_i,
  output logic [95:0]        fpu_operands_o,
  output logic [3:0]         fpu_op_o,
  output logic               fpu_op_mod_o,
  output logic [2:0]         fpu_rnd_mode_o,
  output logic               fpu_flush_o,
  input  logic [31:0]        fpu_result_i,
  input  logic [4:0]         fpu_status_i,
  input  logic               fpu_out_valid_i,
  output logic               fpu_out_ready_o
);

  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ISSUE,
    S_EXEC,
    S_RESULT
  } state_e;

  state_e state_q, state_d;

  logic [IdWidth-1:0] id_q;
  logic [4:0]         rd_q;
  logic [3:0]         op_q;
  logic               mod_q;
  logic [2:0]         rnd_q;
  logic [95:0]        ops_q;
  logic [31:0]        data_q;
  logic               we_q;
  logic [CntW-1:0]    cnt_q;
  logic [4:0]         fflags_q;
  logic               flush_q;

  logic [6:0]  f7;
  logic [2:0]  rm;
  logic        base_ok;
  logic        f_add, f_sub, f_mul, f_div;
  logic        dec_legal;
  logic [3:0]  dec_op;
  logic        dec_mod;
  logic [95:0] dec_ops;
  logic [2:0]  dec_rnd;

  logic issue_fire;
  logic commit_now;
  logic commit_hit;
  logic cap;
  logic tmo;

  logic unused_instr;
  assign unused_instr = ^x_issue_instr_i[24:15];

  assign f7 = x_issue_instr_i[31:25];
  assign rm = x_issue_instr_i[14:12];

  assign base_ok = (x_issue_instr_i[6:0] == 7'b1010011)
                && (x_issue_instr_i[26:25] == 2'b00)
                && (rm != 3'b101)
                && (rm != 3'b110);

  assign f_add = f7 == 7'b0000000;
  assign f_sub = f7 == 7'b0000100;
  assign f_mul = f7 == 7'b0001000;
  assign f_div = f7 == 7'b0001100;

  always_comb begin
    dec_legal = 1'b0;
    dec_op    = 4'd2;
    dec_mod   = 1'b0;
    dec_ops   = '0;
    unique case (1'b1)
      f_add: begin
        dec_legal = base_ok;
        dec_ops   = {x_issue_rs1_i, x_issue_rs0_i, 32'h0};
      end
      f_sub: begin
        dec_legal = base_ok;
        dec_mod   = 1'b1;
        dec_ops   = {x_issue_rs1_i, x_issue_rs0_i, 32'h0};
      end
      f_mul: begin
        dec_legal = base_ok;
        dec_op    = 4'd3;
        dec_ops   = {32'h0, x_issue_rs1_i, x_issue_rs0_i};
      end
      f_div: begin
        dec_legal = base_ok;
        dec_op    = 4'd4;
        dec_ops   = {32'h0, x_issue_rs1_i, x_issue_rs0_i};
      end
      default: begin
        dec_legal = 1'b0;
      end
    endcase
  end

  assign dec_rnd = (rm == 3'b111) ? frm_i : rm;

  assign issue_fire = (state_q == S_IDLE) && x_issue_valid_i && dec_legal;

  // Commit may arrive in the same cycle as the issue handshake.
  assign commit_now = x_commit_valid_i && (x_commit_id_i == x_issue_id_i);
  assign commit_hit = x_commit_valid_i && (x_commit_id_i == id_q);

  // Zero-latency fpnew can answer in the very cycle it takes the request.
  assign cap = ((state_q == S_ISSUE) && fpu_in_ready_i && fpu_out_valid_i)
            || ((state_q == S_EXEC) && fpu_out_valid_i);
  assign tmo = (state_q == S_EXEC) && !fpu_out_valid_i && (cnt_q == CntLast);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (issue_fire) begin
          if (commit_now) begin
            state_d = x_commit_kill_i ? S_IDLE : S_ISSUE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (commit_hit) begin
          state_d = x_commit_kill_i ? S_IDLE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (fpu_in_ready_i) begin
          state_d = fpu_out_valid_i ? S_RESULT : S_EXEC;
        end
      end
      S_EXEC: begin
        if (cap || tmo) begin
          state_d = S_RESULT;
        end
      end
      S_RESULT: begin
        if (x_result_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    x_issue_ready_o  = state_q == S_IDLE;
    fpu_in_valid_o   = state_q == S_ISSUE;
    fpu_out_ready_o  = (state_q == S_ISSUE) || (state_q == S_EXEC);
    x_result_valid_o = state_q == S_RESULT;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q     <= '0;
      rd_q     <= '0;
      op_q     <= '0;
      mod_q    <= 1'b0;
      rnd_q    <= '0;
      ops_q    <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      fflags_q <= '0;
      flush_q  <= 1'b0;
    end else begin
      if (issue_fire) begin
        id_q  <= x_issue_id_i;
        rd_q  <= x_issue_instr_i[11:7];
        op_q  <= dec_op;
        mod_q <= dec_mod;
        rnd_q <= dec_rnd;
        ops_q <= dec_ops;
      end
      if (state_q != S_ISSUE && state_d == S_ISSUE) begin
        cnt_q <= '0;
      end else if (state_q == S_EXEC) begin
        cnt_q <= cnt_q + CntW'(1);
      end
      if (cap) begin
        data_q <= fpu_result_i;
        we_q   <= 1'b1;
      end else if (tmo) begin
        data_q <= '0;
        we_q   <= 1'b0;
      end
      // New status bits win over a same-cycle clear.
      fflags_q <= (fflags_clr_i ? 5'b0 : fflags_q)
                | (cap ? fpu_status_i : 5'b0);
      flush_q  <= tmo;
    end
  end

  assign x_issue_accept_o    = x_issue_valid_i && dec_legal;
  assign x_issue_writeback_o = x_issue_accept_o;
  assign x_result_id_o       = id_q;
  assign x_result_rd_o       = rd_q;
  assign x_result_data_o     = data_q;
  assign x_result_we_o       = we_q;
  assign fflags_o            = fflags_q;
  assign fpu_operands_o      = ops_q;
  assign fpu_op_o            = op_q;
  assign fpu_op_mod_o        = mod_q;
  assign fpu_rnd_mode_o      = rnd_q;
  assign fpu_flush_o         = flush_q;

endmodule
